// File: rtl/cla_32bit_lcu_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_32bit_lcu_adder_pkg
// Brief    : Shared width constants for the 32-bit lookahead adder.
// Revision : 1.0
// ============================================================================
package cla_32bit_lcu_adder_pkg;

  localparam int WIDTH   = 32;
  localparam int BLK     = 4;
  localparam int NUM_BLK = WIDTH / BLK;

endpackage : cla_32bit_lcu_adder_pkg
`default_nettype wire

// File: rtl/cla_4bit_block.sv
`default_nettype none
// ============================================================================
// Module   : cla_4bit_block
// Brief    : 4-bit leaf carry-lookahead block producing sum and block G/P.
// Revision : 1.0
// ============================================================================
import cla_32bit_lcu_adder_pkg::*;

module cla_4bit_block (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           G,
  output logic           P
);

  logic [BLK-1:0] w_g;
  logic [BLK-1:0] w_p;
  logic [BLK-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Internal carries are flat sum-of-products of cin, never chained.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ w_c;

  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign P = &w_p;

endmodule : cla_4bit_block
`default_nettype wire

// File: rtl/lcu_4.sv
`default_nettype none
// ============================================================================
// Module   : lcu_4
// Brief    : Two-level lookahead carry unit over four (G,P) pairs.
// Revision : 1.0
// ============================================================================
import cla_32bit_lcu_adder_pkg::*;

module lcu_4 (
  input  logic [BLK-1:0] G,
  input  logic [BLK-1:0] P,
  input  logic           cin,
  output logic [3:1]     c,
  output logic           Gg,
  output logic           Pg
);

  assign c[1] = G[0] | (P[0] & cin);
  assign c[2] = G[1] | (P[1] & G[0]) | (P[1] & P[0] & cin);
  assign c[3] = G[2] | (P[2] & G[1]) | (P[2] & P[1] & G[0])
              | (P[2] & P[1] & P[0] & cin);

  assign Gg = G[3] | (P[3] & G[2]) | (P[3] & P[2] & G[1])
            | (P[3] & P[2] & P[1] & G[0]);
  assign Pg = &P;

endmodule : lcu_4
`default_nettype wire

// File: rtl/cla_32bit_lcu_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_32bit_lcu_adder
// Brief    : Registered 32-bit adder: leaf CLA blocks -> group LCUs -> top LCU.
// Revision : 1.0
// ============================================================================
import cla_32bit_lcu_adder_pkg::*;

module cla_32bit_lcu_adder (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [NUM_BLK-1:0] w_blk_g;
  logic [NUM_BLK-1:0] w_blk_p;
  logic [NUM_BLK-1:0] w_blk_cin;
  logic [WIDTH-1:0]   w_sum;

  logic [3:1] w_grp0_c;
  logic [3:1] w_grp1_c;
  logic [1:0] w_grp_g;
  logic [1:0] w_grp_p;
  logic [3:1] w_top_c;
  logic       w_c16;
  logic       w_g_top;
  logic       w_p_top;
  logic       unused_top_c;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_d;
  logic             c_out_q;

  assign w_blk_cin = {w_grp1_c, w_c16, w_grp0_c, c_in};

  for (genvar i = 0; i < NUM_BLK; i++) begin : g_leaf
    cla_4bit_block u_blk (
      .a   (in1[i*BLK +: BLK]),
      .b   (in2[i*BLK +: BLK]),
      .cin (w_blk_cin[i]),
      .s   (w_sum[i*BLK +: BLK]),
      .G   (w_blk_g[i]),
      .P   (w_blk_p[i])
    );
  end

  lcu_4 u_lcu_grp0 (
    .G   (w_blk_g[3:0]),
    .P   (w_blk_p[3:0]),
    .cin (c_in),
    .c   (w_grp0_c),
    .Gg  (w_grp_g[0]),
    .Pg  (w_grp_p[0])
  );

  lcu_4 u_lcu_grp1 (
    .G   (w_blk_g[7:4]),
    .P   (w_blk_p[7:4]),
    .cin (w_c16),
    .c   (w_grp1_c),
    .Gg  (w_grp_g[1]),
    .Pg  (w_grp_p[1])
  );

  // Unused upper slots padded with G=0/P=1 so Gg/Pg reduce to the two-group terms.
  lcu_4 u_lcu_top (
    .G   ({2'b00, w_grp_g}),
    .P   ({2'b11, w_grp_p}),
    .cin (c_in),
    .c   (w_top_c),
    .Gg  (w_g_top),
    .Pg  (w_p_top)
  );

  assign w_c16        = w_top_c[1];
  assign unused_top_c = ^w_top_c[3:2];

  always_comb begin
    sum_d   = w_sum;
    c_out_d = w_g_top | (w_p_top & c_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule : cla_32bit_lcu_adder
`default_nettype wire

// File: tb/tb_cla_32bit_lcu_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_32bit_lcu_adder
// Brief    : Scoreboard bench: driver pushes reference results, monitor pops/compares.
// Revision : 1.0
// ============================================================================
module tb_cla_32bit_lcu_adder;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        c_in;
  logic [31:0] sum;
  logic        c_out;

  typedef struct {
    logic [32:0] exp;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  cla_32bit_lcu_adder dut (
    .clk   (clk),
    .rst   (rst),
    .in1   (in1),
    .in2   (in2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit unsigned arithmetic, zero while in reset.
  function automatic logic [32:0] ref_add(input logic r, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [32:0] t;
    if (r) return 33'd0;
    t = {1'b0, a} + {1'b0, b} + {32'd0, c};
    return t;
  endfunction

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    in1  = a;
    in2  = b;
    c_in = c;
    e.exp = ref_add(r, a, b, c);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one result is presented per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if ({c_out, sum} !== e.exp) begin
          n_mismatched++;
          $display("FAIL %s: got c_out=%0b sum=%h, expected c_out=%0b sum=%h",
                   e.tag, c_out, sum, e.exp[32], e.exp[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic        c;
    logic [31:0] patt [4];
    n_compared   = 0;
    n_mismatched = 0;
    rst  = 1'b1;
    in1  = '0;
    in2  = '0;
    c_in = 1'b0;
    patt[0] = 32'hFFFF_FFFF;
    patt[1] = 32'h0000_0000;
    patt[2] = 32'h8000_0000;
    patt[3] = 32'h0000_FFFF;
    repeat (2) @(posedge clk);

    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "reset_ones");
    drive(1'b1, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx, "reset_x");
    drive(1'b0, 32'd2147483648, 32'd1073741824, 1'b0, "plain_add");
    drive(1'b0, 32'd214748348,  32'd1073741824, 1'b0, "mixed_a");
    drive(1'b0, 32'd147483648,  32'd3741824,    1'b0, "mixed_b");
    drive(1'b0, 32'd2147483648, 32'd2147483648, 1'b0, "overflow");
    drive(1'b0, 32'hFFFF_FFFF,  32'h0000_0000,  1'b1, "full_chain");
    drive(1'b0, 32'h0000_FFFF,  32'h0000_0001,  1'b0, "group_cross");
    drive(1'b0, 32'h0000_FFFF,  32'h0000_0000,  1'b1, "group_cross_cin");
    drive(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, "max_all");
    drive(1'b0, 32'h0000_0000,  32'h0000_0000,  1'b0, "zero");
    drive(1'b0, 32'h00FF_FFFF,  32'h0000_0000,  1'b1, "block_cross");

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      // Occasionally pick long-carry patterns that pure random rarely hits.
      if ($urandom_range(0, 7) == 0) a = patt[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) b = ~a;
      if (i == 500 || i == 777)
        drive(1'b1, a, b, c, "rand_mid_reset");
      else
        drive(1'b0, a, b, c, "rand");
    end

    repeat (3) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_cla_32bit_lcu_adder
`default_nettype wire
